// File: rtl/reg_bank.sv
// reg_bank: Wishbone-slave register bank for CPU control, event status and IRQ masking.
//
// Register map:
//   0  CPU       rw  bit0 READY -> cpu_ready_o, bit1 RESET (reads back cpu_reset_o), rest 0
//   1  STATUS    ro  sticky event bits; write 1 to a bit to clear it
//   2  IRQ_MASK  rw  irq_o = |(STATUS & IRQ_MASK), registered
//   3.. REG_COUNT-1  scratch registers
//
// Ports:
//   clock_i, reset_i        clock and synchronous active-high reset
//   wb_addr_i/wb_data_i     bus address and write data
//   wb_we_i/wb_cyc_i/wb_stb_i  bus control
//   wb_data_o/wb_ack_o      registered read data and single-cycle acknowledge
//   event_i                 per-bit event pulses feeding STATUS
//   cpu_ready_o/cpu_reset_o CPU control outputs
//   irq_o                   registered interrupt request
module reg_bank #(
  parameter int unsigned DATA_WIDTH   = 8,
  parameter int unsigned REG_COUNT    = 4,
  parameter int unsigned RESET_CYCLES = 64,
  parameter bit          AUTO_RELEASE = 1'b1,
  localparam int unsigned ADDR_W      = $clog2(REG_COUNT + 1)
) (
  input  logic                  clock_i,
  input  logic                  reset_i,
  input  logic [ADDR_W-1:0]     wb_addr_i,
  input  logic [DATA_WIDTH-1:0] wb_data_i,
  output logic [DATA_WIDTH-1:0] wb_data_o,
  input  logic                  wb_we_i,
  input  logic                  wb_cyc_i,
  input  logic                  wb_stb_i,
  output logic                  wb_ack_o,
  input  logic [DATA_WIDTH-1:0] event_i,
  output logic                  cpu_ready_o,
  output logic                  cpu_reset_o,
  output logic                  irq_o
);

  localparam int unsigned CNT_W = $clog2(RESET_CYCLES + 1);
  // Keep the scratch array legal when REG_COUNT leaves no scratch registers.
  localparam int unsigned SCR_N = (REG_COUNT > 3) ? REG_COUNT - 3 : 1;
  localparam logic [CNT_W-1:0] CntLoad = CNT_W'(RESET_CYCLES - 1);
  localparam logic [CNT_W-1:0] CntOne  = CNT_W'(1);

  localparam logic [1:0] StHeld  = 2'd0;
  localparam logic [1:0] StRun   = 2'd1;
  localparam logic [1:0] StPulse = 2'd2;

  logic                  ack_q;
  logic [DATA_WIDTH-1:0] data_q;
  logic                  ready_q;
  logic [DATA_WIDTH-1:0] status_q, status_d;
  logic [DATA_WIDTH-1:0] mask_q;
  logic [DATA_WIDTH-1:0] scratch_q [SCR_N];
  logic [1:0]            state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic                  irq_q;
  logic [DATA_WIDTH-1:0] rdata;

  int unsigned addr_idx;
  logic        access, wr, rd, wr_cpu, wr_status, wr_mask;

  assign addr_idx  = 32'(wb_addr_i);
  // A new access is only accepted while no ack is outstanding, so strobes
  // held high are serviced every other cycle.
  assign access    = wb_cyc_i & wb_stb_i & ~ack_q;
  assign wr        = access & wb_we_i;
  assign rd        = access & ~wb_we_i;
  assign wr_cpu    = wr && (addr_idx == 0);
  assign wr_status = wr && (addr_idx == 1);
  assign wr_mask   = wr && (addr_idx == 2);

  assign wb_ack_o    = ack_q;
  assign wb_data_o   = data_q;
  assign cpu_ready_o = ready_q;
  assign cpu_reset_o = (state_q != StRun);
  assign irq_o       = irq_q;

  always_comb begin
    rdata = '0;
    if (addr_idx == 0) begin
      rdata[0] = ready_q;
      rdata[1] = cpu_reset_o;
    end else if (addr_idx == 1) begin
      rdata = status_q;
    end else if (addr_idx == 2) begin
      rdata = mask_q;
    end else begin
      for (int unsigned i = 0; i < SCR_N; i++) begin
        if ((REG_COUNT > 3) && (addr_idx == i + 3)) rdata = scratch_q[i];
      end
    end
  end

  // Set wins over a simultaneous write-1-to-clear.
  always_comb begin
    status_d = status_q;
    if (wr_status) status_d = status_d & ~wb_data_i;
    status_d = status_d | event_i;
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      StHeld: begin
        if (wr_cpu && !wb_data_i[1]) state_d = StRun;
      end
      StRun: begin
        if (wr_cpu && wb_data_i[1]) begin
          if (AUTO_RELEASE) begin
            state_d = StPulse;
            cnt_d   = CntLoad;
          end else begin
            state_d = StHeld;
          end
        end
      end
      StPulse: begin
        // Writing RESET=0 is ignored so the minimum pulse length always holds.
        if (wr_cpu && wb_data_i[1]) begin
          cnt_d = CntLoad;
        end else if (cnt_q == '0) begin
          state_d = StRun;
        end else begin
          cnt_d = cnt_q - CntOne;
        end
      end
      default: state_d = StHeld;
    endcase
  end

  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      ack_q    <= 1'b0;
      data_q   <= '0;
      ready_q  <= 1'b0;
      status_q <= '0;
      mask_q   <= '0;
      state_q  <= StHeld;
      cnt_q    <= '0;
      irq_q    <= 1'b0;
      for (int unsigned i = 0; i < SCR_N; i++) scratch_q[i] <= '0;
    end else begin
      ack_q    <= access;
      data_q   <= rd ? rdata : '0;
      status_q <= status_d;
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      irq_q    <= |(status_q & mask_q);
      if (wr_cpu)  ready_q <= wb_data_i[0];
      if (wr_mask) mask_q  <= wb_data_i;
      for (int unsigned i = 0; i < SCR_N; i++) begin
        if ((REG_COUNT > 3) && wr && (addr_idx == i + 3)) scratch_q[i] <= wb_data_i;
      end
    end
  end

endmodule

// File: tb/tb_reg_bank.sv
// Bench for reg_bank: an auto-release instance (a_*) and a level-mode instance (b_*)
// share all inputs; a behavioural model tracks registers and the CPU reset output.
module tb_reg_bank;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [2:0] addr = '0;
  logic [7:0] wdata = '0;
  logic       we = 1'b0, cyc = 1'b0, stb = 1'b0;
  logic [7:0] ev = '0;

  logic [7:0] a_data, b_data;
  logic       a_ack, a_ready, a_creset, a_irq;
  logic       b_ack, b_ready, b_creset, b_irq;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  reg_bank #(.DATA_WIDTH(8), .REG_COUNT(4), .RESET_CYCLES(64), .AUTO_RELEASE(1'b1)) dut_a (
    .clock_i(clk), .reset_i(rst), .wb_addr_i(addr), .wb_data_i(wdata), .wb_data_o(a_data),
    .wb_we_i(we), .wb_cyc_i(cyc), .wb_stb_i(stb), .wb_ack_o(a_ack), .event_i(ev),
    .cpu_ready_o(a_ready), .cpu_reset_o(a_creset), .irq_o(a_irq)
  );

  reg_bank #(.DATA_WIDTH(8), .REG_COUNT(4), .RESET_CYCLES(64), .AUTO_RELEASE(1'b0)) dut_b (
    .clock_i(clk), .reset_i(rst), .wb_addr_i(addr), .wb_data_i(wdata), .wb_data_o(b_data),
    .wb_we_i(we), .wb_cyc_i(cyc), .wb_stb_i(stb), .wb_ack_o(b_ack), .event_i(ev),
    .cpu_ready_o(b_ready), .cpu_reset_o(b_creset), .irq_o(b_irq)
  );

  // Behavioural model. Index 0 = auto-release instance, 1 = level instance.
  // CPU reset is high while held, or while a timed pulse has cycles left.
  logic [7:0] m_status = '0, m_mask = '0, m_scr = '0;
  bit         m_ready = 0, m_ack = 0, m_irq = 0;
  bit         m_held [2] = '{1, 1};
  int         m_left [2] = '{0, 0};
  logic [7:0] m_rdata [2] = '{8'h00, 8'h00};

  function automatic bit exp_creset(int d);
    return m_held[d] || (m_left[d] > 0);
  endfunction

  function automatic logic [7:0] model_read(int d, logic [2:0] a);
    case (a)
      3'd0:    return {6'b0, exp_creset(d), m_ready};
      3'd1:    return m_status;
      3'd2:    return m_mask;
      3'd3:    return m_scr;
      default: return 8'h00;
    endcase
  endfunction

  task automatic model_edge();
    bit         acc, pulsing;
    logic [7:0] rd_old [2];
    if (rst) begin
      m_status = '0; m_mask = '0; m_scr = '0; m_ready = 0; m_ack = 0; m_irq = 0;
      for (int d = 0; d < 2; d++) begin
        m_held[d] = 1; m_left[d] = 0; m_rdata[d] = '0;
      end
      return;
    end
    acc = cyc && stb && !m_ack;
    for (int d = 0; d < 2; d++) rd_old[d] = model_read(d, addr);
    m_irq = |(m_status & m_mask);
    for (int d = 0; d < 2; d++) begin
      pulsing = (m_left[d] > 0);
      if (m_left[d] > 0) m_left[d]--;
      if (acc && we && addr == 3'd0) begin
        if (m_held[d]) begin
          if (!wdata[1]) m_held[d] = 0;
        end else if (pulsing) begin
          if (wdata[1]) m_left[d] = 64;
        end else if (wdata[1]) begin
          if (d == 0) m_left[d] = 64;
          else m_held[d] = 1;
        end
      end
    end
    if (acc && we) begin
      case (addr)
        3'd0: m_ready = wdata[0];
        3'd1: m_status = m_status & ~wdata;
        3'd2: m_mask = wdata;
        3'd3: m_scr = wdata;
        default: ;
      endcase
    end
    m_status = m_status | ev;
    m_ack = acc;
    for (int d = 0; d < 2; d++) m_rdata[d] = (acc && !we) ? rd_old[d] : 8'h00;
  endtask

  // One clock: model follows the inputs present at the edge; returns 1 time unit later.
  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  // Single bus access plus the following idle cycle.
  task automatic xfer(input bit w, input logic [2:0] a, input logic [7:0] d,
                      output bit ack_seen, output logic [7:0] rd, output bit ack_after);
    cyc = 1; stb = 1; we = w; addr = a; wdata = d;
    tick();
    ack_seen = a_ack; rd = a_data;
    cyc = 0; stb = 0; we = 0;
    tick();
    ack_after = a_ack;
  endtask

  task automatic test_reset();
    bit ack, ack2; logic [7:0] rd;
    rst = 1; tick(); tick(); rst = 0;
    checks++; if (a_creset !== 1'b1) begin failures++; $display("FAIL reset_creset got=%b want=1", a_creset); end
    checks++; if (a_ready !== 1'b0) begin failures++; $display("FAIL reset_ready got=%b want=0", a_ready); end
    checks++; if (a_irq !== 1'b0) begin failures++; $display("FAIL reset_irq got=%b want=0", a_irq); end
    checks++; if (a_ack !== 1'b0) begin failures++; $display("FAIL reset_ack got=%b want=0", a_ack); end
    checks++; if (a_data !== 8'h00) begin failures++; $display("FAIL reset_data got=%h want=00", a_data); end
    xfer(0, 3'd0, 8'h00, ack, rd, ack2);
    checks++; if (ack !== 1'b1) begin failures++; $display("FAIL reset_read_ack got=%b want=1", ack); end
    checks++; if (rd !== 8'h02) begin failures++; $display("FAIL reset_read_cpu got=%h want=02", rd); end
    checks++; if (ack2 !== 1'b0) begin failures++; $display("FAIL reset_ack_one_cycle got=%b want=0", ack2); end
  endtask

  task automatic test_cpu_run();
    bit ack, ack2; logic [7:0] rd;
    cyc = 1; stb = 1; we = 1; addr = 3'd0; wdata = 8'h01;
    tick();
    cyc = 0; stb = 0; we = 0;
    checks++; if (a_creset !== 1'b0) begin failures++; $display("FAIL run_creset got=%b want=0", a_creset); end
    checks++; if (a_ready !== 1'b1) begin failures++; $display("FAIL run_ready got=%b want=1", a_ready); end
    checks++; if (a_ack !== 1'b1) begin failures++; $display("FAIL run_write_ack got=%b want=1", a_ack); end
    tick();
    xfer(0, 3'd0, 8'h00, ack, rd, ack2);
    checks++; if (rd !== 8'h01) begin failures++; $display("FAIL run_read_cpu got=%h want=01", rd); end
  endtask

  // Pulse from RUN; RESET=0 at edge 10 is ignored, RESET=1 at edge 40 restarts the 64 cycles.
  task automatic test_pulse();
    bit want;
    for (int k = 0; k <= 110; k++) begin
      cyc = (k == 0 || k == 10 || k == 40); stb = cyc; we = cyc; addr = 3'd0;
      wdata = (k == 10) ? 8'h01 : 8'h03;
      tick();
      cyc = 0; stb = 0; we = 0;
      want = (k < 104);
      checks++;
      if (a_creset !== want) begin
        failures++; $display("FAIL pulse_creset k=%0d got=%b want=%b", k, a_creset, want);
      end
    end
    checks++; if (a_ready !== 1'b1) begin failures++; $display("FAIL pulse_ready got=%b want=1", a_ready); end
  endtask

  task automatic test_status();
    bit ack, ack2; logic [7:0] rd;
    ev = 8'h05; tick(); ev = 8'h00;
    xfer(0, 3'd1, 8'h00, ack, rd, ack2);
    checks++; if (rd !== 8'h05) begin failures++; $display("FAIL status_set got=%h want=05", rd); end
    checks++; if (a_irq !== 1'b0) begin failures++; $display("FAIL status_irq_masked got=%b want=0", a_irq); end
    xfer(1, 3'd2, 8'h04, ack, rd, ack2);
    checks++; if (a_irq !== 1'b1) begin failures++; $display("FAIL status_irq_on got=%b want=1", a_irq); end
    xfer(1, 3'd1, 8'h04, ack, rd, ack2);
    checks++; if (a_irq !== 1'b0) begin failures++; $display("FAIL status_irq_off got=%b want=0", a_irq); end
    xfer(0, 3'd1, 8'h00, ack, rd, ack2);
    checks++; if (rd !== 8'h01) begin failures++; $display("FAIL status_w1c got=%h want=01", rd); end
    ev = 8'h01; cyc = 1; stb = 1; we = 1; addr = 3'd1; wdata = 8'h01;
    tick();
    ev = 8'h00; cyc = 0; stb = 0; we = 0;
    tick();
    xfer(0, 3'd1, 8'h00, ack, rd, ack2);
    checks++; if (rd !== 8'h01) begin failures++; $display("FAIL status_set_wins got=%h want=01", rd); end
    xfer(1, 3'd1, 8'h01, ack, rd, ack2);
    xfer(0, 3'd1, 8'h00, ack, rd, ack2);
    checks++; if (rd !== 8'h00) begin failures++; $display("FAIL status_cleared got=%h want=00", rd); end
  endtask

  task automatic test_addr();
    bit ack, ack2; logic [7:0] rd, want;
    xfer(1, 3'd7, 8'hFF, ack, rd, ack2);
    checks++; if (ack !== 1'b1) begin failures++; $display("FAIL addr_oob_write_ack got=%b want=1", ack); end
    xfer(0, 3'd7, 8'h00, ack, rd, ack2);
    checks++; if (ack !== 1'b1) begin failures++; $display("FAIL addr_oob_read_ack got=%b want=1", ack); end
    checks++; if (rd !== 8'h00) begin failures++; $display("FAIL addr_oob_read got=%h want=00", rd); end
    xfer(0, 3'd2, 8'h00, ack, rd, ack2);
    checks++; if (rd !== 8'h04) begin failures++; $display("FAIL addr_mask_kept got=%h want=04", rd); end
    want = model_read(0, 3'd0);
    xfer(0, 3'd0, 8'h00, ack, rd, ack2);
    checks++; if (rd !== want) begin failures++; $display("FAIL addr_cpu_kept got=%h want=%h", rd, want); end
    xfer(1, 3'd3, 8'hA5, ack, rd, ack2);
    xfer(0, 3'd3, 8'h00, ack, rd, ack2);
    checks++; if (rd !== 8'hA5) begin failures++; $display("FAIL addr_scratch got=%h want=a5", rd); end
  endtask

  task automatic test_level();
    bit ack, ack2, stayed; logic [7:0] rd;
    rst = 1; tick(); tick(); rst = 0;
    xfer(1, 3'd0, 8'h01, ack, rd, ack2);
    checks++; if (b_creset !== 1'b0) begin failures++; $display("FAIL level_run got=%b want=0", b_creset); end
    xfer(1, 3'd0, 8'h03, ack, rd, ack2);
    stayed = 1;
    for (int k = 0; k < 210; k++) begin
      tick();
      if (b_creset !== 1'b1) stayed = 0;
    end
    checks++; if (stayed !== 1'b1) begin failures++; $display("FAIL level_held got=%b want=1", stayed); end
    checks++; if (a_creset !== 1'b0) begin failures++; $display("FAIL level_auto_done got=%b want=0", a_creset); end
    xfer(1, 3'd0, 8'h01, ack, rd, ack2);
    checks++; if (b_creset !== 1'b0) begin failures++; $display("FAIL level_release got=%b want=0", b_creset); end
    // Reset while ack is high.
    cyc = 1; stb = 1; we = 1; addr = 3'd3; wdata = 8'h3C;
    tick();
    checks++; if (b_ack !== 1'b1) begin failures++; $display("FAIL level_ack_before got=%b want=1", b_ack); end
    rst = 1; cyc = 0; stb = 0; we = 0;
    tick();
    checks++; if (b_ack !== 1'b0) begin failures++; $display("FAIL level_ack_reset got=%b want=0", b_ack); end
    checks++; if (b_creset !== 1'b1) begin failures++; $display("FAIL level_reset_held got=%b want=1", b_creset); end
    // Reset coinciding with a strobe: no ack, no commit.
    cyc = 1; stb = 1; we = 1; addr = 3'd2; wdata = 8'h7E;
    tick();
    checks++; if (a_ack !== 1'b0) begin failures++; $display("FAIL reset_strobe_ack got=%b want=0", a_ack); end
    rst = 0; cyc = 0; stb = 0; we = 0;
    tick();
    xfer(0, 3'd2, 8'h00, ack, rd, ack2);
    checks++; if (rd !== 8'h00) begin failures++; $display("FAIL reset_strobe_nocommit got=%h want=00", rd); end
  endtask

  task automatic test_random();
    for (int k = 0; k < 1500; k++) begin
      rst   = ($urandom_range(0, 299) == 0);
      cyc   = ($urandom_range(0, 3) != 0);
      stb   = cyc ? ($urandom_range(0, 3) != 0) : 1'($urandom_range(0, 1));
      we    = 1'($urandom_range(0, 1));
      addr  = ($urandom_range(0, 5) == 0) ? 3'($urandom_range(4, 7)) : 3'($urandom_range(0, 3));
      wdata = 8'($urandom);
      if (addr == 3'd0) wdata[1] = ($urandom_range(0, 7) == 0);
      ev    = ($urandom_range(0, 3) == 0) ? 8'($urandom) & 8'($urandom) : 8'h00;
      tick();
      checks++; if (a_ack !== m_ack) begin failures++; $display("FAIL rnd_ack k=%0d got=%b want=%b", k, a_ack, m_ack); end
      if (m_ack) begin
        checks++; if (a_data !== m_rdata[0]) begin failures++; $display("FAIL rnd_data_a k=%0d got=%h want=%h", k, a_data, m_rdata[0]); end
        checks++; if (b_data !== m_rdata[1]) begin failures++; $display("FAIL rnd_data_b k=%0d got=%h want=%h", k, b_data, m_rdata[1]); end
      end
      checks++; if (a_creset !== exp_creset(0)) begin failures++; $display("FAIL rnd_creset_a k=%0d got=%b want=%b", k, a_creset, exp_creset(0)); end
      checks++; if (b_creset !== exp_creset(1)) begin failures++; $display("FAIL rnd_creset_b k=%0d got=%b want=%b", k, b_creset, exp_creset(1)); end
      checks++; if (a_ready !== m_ready) begin failures++; $display("FAIL rnd_ready k=%0d got=%b want=%b", k, a_ready, m_ready); end
      checks++; if (a_irq !== m_irq) begin failures++; $display("FAIL rnd_irq k=%0d got=%b want=%b", k, a_irq, m_irq); end
    end
    rst = 0; cyc = 0; stb = 0; we = 0; ev = 8'h00;
    tick();
  endtask

  initial begin
    test_reset();
    test_cpu_run();
    test_pulse();
    test_status();
    test_addr();
    test_level();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
